// File: rtl/jtag_pkg_hdl.sv
// Shared types for the JTAG shift master: TAP state encoding, command opcodes,
// controller states and the TAP next-state function.
package jtag_pkg_hdl;

  localparam int JTAG_RESET_TMS_CNT = 5;

  typedef enum logic [3:0] {
    TLR       = 4'd0,
    RTI       = 4'd1,
    SEL_DR    = 4'd2,
    CAP_DR    = 4'd3,
    SHIFT_DR  = 4'd4,
    EXIT1_DR  = 4'd5,
    PAUSE_DR  = 4'd6,
    EXIT2_DR  = 4'd7,
    UPDATE_DR = 4'd8,
    SEL_IR    = 4'd9,
    CAP_IR    = 4'd10,
    SHIFT_IR  = 4'd11,
    EXIT1_IR  = 4'd12,
    PAUSE_IR  = 4'd13,
    EXIT2_IR  = 4'd14,
    UPDATE_IR = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_DR    = 2'd0,
    OP_IR    = 2'd1,
    OP_RESET = 2'd2,
    OP_RSVD  = 2'd3
  } jtag_op_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_WRAP  = 3'd4,
    ST_RESP  = 3'd5
  } ctl_state_t;

  // IEEE 1149.1 TAP transition taken at a TCK rise for the given TMS
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:       tap_next = tms ? TLR       : RTI;
      RTI:       tap_next = tms ? SEL_DR    : RTI;
      SEL_DR:    tap_next = tms ? SEL_IR    : CAP_DR;
      CAP_DR:    tap_next = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  tap_next = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  tap_next = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  tap_next = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  tap_next = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: tap_next = tms ? SEL_DR    : RTI;
      SEL_IR:    tap_next = tms ? TLR       : CAP_IR;
      CAP_IR:    tap_next = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  tap_next = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  tap_next = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  tap_next = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  tap_next = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: tap_next = tms ? SEL_DR    : RTI;
      default:   tap_next = TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: divides the system clock by 2*CLK_DIV while run is high and
// flags the clock cycle on which TCK rises or falls. TCK parks low when stopped.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = run && (cnt == CW'(CLK_DIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  // Half-period counter; TCK toggles each time it wraps and is cleared when stopped
  always_ff @(posedge clock) begin
    if (!reset || !run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG shift master: command/response front end driving TCK/TMS/TDI, tracking
// the TAP state and capturing TDO. Optional TRST_n output under JTAG_TRST_EN.
module jtag_shift_master
  import jtag_pkg_hdl::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = $clog2(DATA_W + 1),
  parameter int CLK_DIV = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [3:0]        tap_state,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
`ifdef JTAG_TRST_EN
  , output logic            TRST_n
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  ctl_state_t        st;
  tap_state_t        ts;
  jtag_op_t          op_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  bcnt;
  logic [2:0]        rcnt;
  logic              init_q;
  logic              run, rise, fall;
  logic              shifting, last_bit, resetting, done_rise, check_err;
  logic              scan_tms, next_tms;
  logic [IDX_W-1:0]  bidx;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .tck   (TCK),
    .rise  (rise),
    .fall  (fall)
  );

  assign tap_state = ts;
  assign bidx      = bcnt[IDX_W-1:0];
  assign shifting  = (ts == SHIFT_DR) || (ts == SHIFT_IR);
  assign last_bit  = (bcnt == len_q - LEN_W'(1));
  assign resetting = init_q || (op_q == OP_RESET);
  assign check_err = (op_q == OP_RSVD) || (len_q == '0) || (len_q > LEN_W'(DATA_W));
  assign done_rise = resetting ? (rcnt == 3'(JTAG_RESET_TMS_CNT))
                               : ((ts == UPDATE_DR) || (ts == UPDATE_IR));
  assign next_tms  = resetting ? (rcnt < 3'(JTAG_RESET_TMS_CNT)) : scan_tms;

  // TMS a scan needs for the next rise, chosen from the TAP state just reached
  always_comb begin
    scan_tms = 1'b0;
    case (ts)
      RTI:                scan_tms = 1'b1;
      SEL_DR:             scan_tms = (op_q == OP_IR);
      SHIFT_DR, SHIFT_IR: scan_tms = last_bit;
      EXIT1_DR, EXIT1_IR: scan_tms = 1'b1;
      default:            scan_tms = 1'b0;
    endcase
  end

  // Control FSM: init walk, command accept/validate, TCK-strobed scan, response hold
  always_ff @(posedge clock) begin
    if (!reset) begin
      st        <= ST_INIT;
      ts        <= TLR;
      op_q      <= OP_DR;
      len_q     <= '0;
      data_q    <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      init_q    <= 1'b1;
      run       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (st)
        ST_INIT: begin
          init_q <= 1'b1;
          rcnt   <= '0;
          run    <= 1'b1;
          st     <= ST_RUN;
        end
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= jtag_op_t'(cmd_op);
            len_q     <= cmd_len;
            data_q    <= cmd_data;
            st        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          rsp_data <= '0;
          if (check_err) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            st        <= ST_RESP;
          end else begin
            rsp_err <= 1'b0;
            bcnt    <= '0;
            rcnt    <= '0;
            TMS     <= 1'b1;
            TDI     <= 1'b0;
            run     <= 1'b1;
            st      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rise) begin
            ts <= tap_next(ts, TMS);
            if (resetting) begin
              rcnt <= rcnt + 1'b1;
            end
            if (!resetting && shifting) begin
              rsp_data[bidx] <= TDO;
              bcnt           <= bcnt + 1'b1;
            end
            if (done_rise) begin
              run <= 1'b0;
              st  <= ST_WRAP;
            end
          end else if (fall) begin
            TMS <= next_tms;
            TDI <= (!resetting && shifting) ? data_q[bidx] : 1'b0;
          end
        end
        ST_WRAP: begin
          TMS    <= 1'b0;
          TDI    <= 1'b0;
          init_q <= 1'b0;
          if (init_q) begin
            cmd_ready <= 1'b1;
            st        <= ST_IDLE;
          end else begin
            rsp_valid <= 1'b1;
            st        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
            st        <= ST_IDLE;
          end
        end
        default: st <= ST_INIT;
      endcase
    end
  end

`ifdef JTAG_TRST_EN
  // TRST_n is held low through the init walk and every TAP-reset command
  always_ff @(posedge clock) begin
    if (!reset) begin
      TRST_n <= 1'b0;
    end else if (st == ST_CHECK && !check_err && op_q == OP_RESET) begin
      TRST_n <= 1'b0;
    end else if (st == ST_WRAP) begin
      TRST_n <= 1'b1;
    end
  end
`endif

endmodule
